// File: rtl/nvdla_dbb_axi_monitor.sv
// DBB AXI master-port monitor: AW/AR gating, outstanding counters, sticky error record, quiesce handshake.
// Optional response watchdog enabled by defining DBB_MON_TIMEOUT_EN.
module nvdla_dbb_axi_monitor #(
    parameter int unsigned MAX_OUTSTANDING = 16,
    parameter int unsigned CNT_W           = 5,
    parameter int unsigned ID_W            = 8,
    parameter int unsigned TIMEOUT_CYCLES  = 4096,
    parameter int unsigned TO_W            = 16
) (
    input  logic             core_clk,
    input  logic             rstn,
    input  logic             s_awvalid,
    output logic             s_awready,
    output logic             m_awvalid,
    input  logic             m_awready,
    input  logic             s_arvalid,
    output logic             s_arready,
    output logic             m_arvalid,
    input  logic             m_arready,
    input  logic             bvalid,
    input  logic             bready,
    input  logic [ID_W-1:0]  bid,
    input  logic [1:0]       bresp,
    input  logic             rvalid,
    input  logic             rready,
    input  logic             rlast,
    input  logic [ID_W-1:0]  rid,
    input  logic [1:0]       rresp,
    input  logic             quiesce_req,
    output logic             quiesce_ack,
    output logic [CNT_W-1:0] wr_outstanding,
    output logic [CNT_W-1:0] rd_outstanding,
    output logic             err_valid,
    output logic [1:0]       err_code,
    output logic             err_is_rd,
    output logic [ID_W-1:0]  err_id,
    output logic [1:0]       err_resp,
    input  logic             err_clr
);

    logic [CNT_W-1:0] wr_cnt, rd_cnt;
    logic             blk_aw, blk_ar;
    logic             aw_hs, ar_hs, b_hs, r_hs, r_done;
    logic             to_fire;
    logic             new_err, new_is_rd;
    logic [1:0]       new_code, new_resp;
    logic [ID_W-1:0]  new_id;

    assign blk_aw    = quiesce_req | (wr_cnt == CNT_W'(MAX_OUTSTANDING));
    assign blk_ar    = quiesce_req | (rd_cnt == CNT_W'(MAX_OUTSTANDING));
    assign m_awvalid = s_awvalid & ~blk_aw;
    assign s_awready = m_awready & ~blk_aw;
    assign m_arvalid = s_arvalid & ~blk_ar;
    assign s_arready = m_arready & ~blk_ar;

    assign aw_hs  = m_awvalid & m_awready;
    assign ar_hs  = m_arvalid & m_arready;
    assign b_hs   = bvalid & bready;
    assign r_hs   = rvalid & rready;
    assign r_done = r_hs & rlast;

    assign wr_outstanding = wr_cnt;
    assign rd_outstanding = rd_cnt;

    // A response arriving with the counter at zero leaves it at zero rather than wrapping.
    always_ff @(posedge core_clk or negedge rstn) begin
        if (!rstn) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (aw_hs && !b_hs)
                wr_cnt <= wr_cnt + CNT_W'(1);
            else if (b_hs && !aw_hs && wr_cnt != '0)
                wr_cnt <= wr_cnt - CNT_W'(1);
            if (ar_hs && !r_done)
                rd_cnt <= rd_cnt + CNT_W'(1);
            else if (r_done && !ar_hs && rd_cnt != '0)
                rd_cnt <= rd_cnt - CNT_W'(1);
        end
    end

`ifdef DBB_MON_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
    logic            to_busy;

    assign to_busy = ((wr_cnt | rd_cnt) != '0) && !b_hs && !r_hs;
    assign to_fire = to_busy && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Saturates at the limit so the timeout is reported only once per stall.
    always_ff @(posedge core_clk or negedge rstn) begin
        if (!rstn)
            to_cnt <= '0;
        else if (!to_busy)
            to_cnt <= '0;
        else if (to_cnt != TO_W'(TIMEOUT_CYCLES))
            to_cnt <= to_cnt + TO_W'(1);
    end
`else
    assign to_fire = 1'b0;
`endif

    // Write side before read side; bad response before unexpected before timeout.
    always_comb begin
        new_err   = 1'b1;
        new_code  = 2'b00;
        new_is_rd = 1'b0;
        new_id    = '0;
        new_resp  = 2'b00;
        if (b_hs && bresp[1]) begin
            new_code = 2'b01;
            new_id   = bid;
            new_resp = bresp;
        end else if (b_hs && wr_cnt == '0) begin
            new_code = 2'b10;
            new_id   = bid;
        end else if (r_hs && rresp[1]) begin
            new_code  = 2'b01;
            new_is_rd = 1'b1;
            new_id    = rid;
            new_resp  = rresp;
        end else if (r_done && rd_cnt == '0) begin
            new_code  = 2'b10;
            new_is_rd = 1'b1;
            new_id    = rid;
        end else if (to_fire) begin
            new_code  = 2'b11;
            new_is_rd = (wr_cnt == '0);
        end else begin
            new_err = 1'b0;
        end
    end

    always_ff @(posedge core_clk or negedge rstn) begin
        if (!rstn) begin
            err_valid   <= 1'b0;
            err_code    <= 2'b00;
            err_is_rd   <= 1'b0;
            err_id      <= '0;
            err_resp    <= 2'b00;
            quiesce_ack <= 1'b0;
        end else begin
            if (new_err && (!err_valid || err_clr)) begin
                err_valid <= 1'b1;
                err_code  <= new_code;
                err_is_rd <= new_is_rd;
                err_id    <= new_id;
                err_resp  <= new_resp;
            end else if (err_clr) begin
                err_valid <= 1'b0;
                err_code  <= 2'b00;
                err_is_rd <= 1'b0;
                err_id    <= '0;
                err_resp  <= 2'b00;
            end
            quiesce_ack <= quiesce_req && wr_cnt == '0 && rd_cnt == '0;
        end
    end

endmodule
